// File: rtl/ch2_4_mux.sv
// Four-lane mux with a combinational output plus an enabled registered copy,
// registered select, select-change pulse and saturating change counter.
`timescale 1ns/1ps
module ch2_4_mux #(
  parameter int DATA_W = 1,
  parameter int CNT_W  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DATA_W-1:0]   I,
  input  logic [1:0]            S,
  input  logic                  en,
  output logic [DATA_W-1:0]     Z,
  output logic [DATA_W-1:0]     Z_q,
  output logic [1:0]            sel_q,
  output logic                  sel_chg,
  output logic [CNT_W-1:0]      chg_cnt
);

  logic [DATA_W-1:0] w_lane [4];
  logic [DATA_W-1:0] w_z;
  logic              w_sel_diff;
  logic              w_cnt_max;

  logic [DATA_W-1:0] r_z_q;
  logic [1:0]        r_sel_q;
  logic              r_sel_chg;
  logic [CNT_W-1:0]  r_chg_cnt;

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign w_lane[gi] = I[gi*DATA_W +: DATA_W];
  end

  // Unknown select propagates as X in simulation rather than picking a lane.
  always_comb begin
    w_z = 'x;
    case (S)
      2'b00:   w_z = w_lane[0];
      2'b01:   w_z = w_lane[1];
      2'b10:   w_z = w_lane[2];
      2'b11:   w_z = w_lane[3];
      default: w_z = 'x;
    endcase
  end

  assign w_sel_diff = en && (S != r_sel_q);
  assign w_cnt_max  = &r_chg_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_z_q     <= '0;
      r_sel_q   <= '0;
      r_sel_chg <= 1'b0;
      r_chg_cnt <= '0;
    end else begin
      if (en) begin
        r_z_q   <= w_z;
        r_sel_q <= S;
      end
      // Count moves together with the pulse so both are visible after the same edge.
      r_sel_chg <= w_sel_diff;
      if (w_sel_diff && !w_cnt_max) begin
        r_chg_cnt <= r_chg_cnt + 1'b1;
      end
    end
  end

  assign Z       = w_z;
  assign Z_q     = r_z_q;
  assign sel_q   = r_sel_q;
  assign sel_chg = r_sel_chg;
  assign chg_cnt = r_chg_cnt;

endmodule

// File: tb/tb_ch2_4_mux.sv
// Directed self-checking bench for ch2_4_mux (DATA_W=1, CNT_W=8).
`timescale 1ns/1ps
module tb_ch2_4_mux;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] I;
  logic [1:0] S;
  logic       en;
  logic       Z;
  logic       Z_q;
  logic [1:0] sel_q;
  logic       sel_chg;
  logic [7:0] chg_cnt;

  int total = 0;
  int bad   = 0;

  ch2_4_mux #(.DATA_W(1), .CNT_W(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .I       (I),
    .S       (S),
    .en      (en),
    .Z       (Z),
    .Z_q     (Z_q),
    .sel_q   (sel_q),
    .sel_chg (sel_chg),
    .chg_cnt (chg_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
      else begin
        bad++;
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic exp_z [4];
    logic [3:0] lanes;
    exp_z = '{1'b0, 1'b1, 1'b0, 1'b1};

    rst = 1'b1; en = 1'b0; S = 2'b00; I = 4'b0000;
    #1;
    check("rst_zq",  32'(Z_q),     32'd0);
    check("rst_selq", 32'(sel_q),  32'd0);
    check("rst_chg", 32'(sel_chg), 32'd0);
    check("rst_cnt", 32'(chg_cnt), 32'd0);

    // Periodic lane patterns with S stepping every 25 units, under reset.
    for (int t = 0; t < 100; t++) begin
      lanes[0] = ((t % 2) >= 1);
      lanes[1] = ((t % 6) < 3);
      lanes[2] = ((t % 10) >= 5);
      lanes[3] = ((t % 18) < 9);
      I = lanes;
      S = 2'(t / 25);
      #1;
      check($sformatf("track_t%0d", t), 32'(Z), 32'(lanes[t / 25]));
    end

    // First enabled edge after reset compares against sel_q=00.
    @(negedge clk);
    rst = 1'b0; I = 4'b0100; S = 2'b10; en = 1'b1;
    @(posedge clk); #1;
    check("first_chg",  32'(sel_chg), 32'd1);
    check("first_cnt",  32'(chg_cnt), 32'd1);
    check("first_selq", 32'(sel_q),   32'd2);
    check("first_zq",   32'(Z_q),     32'd1);
    @(posedge clk); #1;
    check("second_chg", 32'(sel_chg), 32'd0);
    check("second_cnt", 32'(chg_cnt), 32'd1);

    // Sweep with I=1010: Z and then Z_q follow lanes 0..3.
    I = 4'b1010;
    for (int s = 0; s < 4; s++) begin
      S = 2'(s);
      #1;
      check($sformatf("sweep_z_s%0d", s), 32'(Z), 32'(exp_z[s]));
      @(posedge clk); #1;
      check($sformatf("sweep_zq_s%0d", s), 32'(Z_q), 32'(exp_z[s]));
      check($sformatf("sweep_chg_s%0d", s), 32'(sel_chg), 32'd1);
    end
    check("sweep_cnt", 32'(chg_cnt), 32'd5);

    // Disabled edges: S moves 00 -> 10 -> 11, registers hold.
    en = 1'b0;
    S = 2'b00; @(posedge clk); #1;
    check("hold0_zq", 32'(Z_q), 32'd1);
    check("hold0_chg", 32'(sel_chg), 32'd0);
    S = 2'b10; @(posedge clk); #1;
    check("hold1_selq", 32'(sel_q), 32'd3);
    check("hold1_cnt", 32'(chg_cnt), 32'd5);
    S = 2'b11; @(posedge clk); #1;
    check("hold2_zq", 32'(Z_q), 32'd1);
    check("hold2_selq", 32'(sel_q), 32'd3);
    check("hold2_cnt", 32'(chg_cnt), 32'd5);
    check("hold2_chg", 32'(sel_chg), 32'd0);

    // Between-edge glitch on S that returns before the edge.
    en = 1'b1;
    S = 2'b00; #2; S = 2'b11;
    @(posedge clk); #1;
    check("glitch_chg", 32'(sel_chg), 32'd0);
    check("glitch_cnt", 32'(chg_cnt), 32'd5);
    check("glitch_zq",  32'(Z_q),     32'd1);

    // Mid-cycle asynchronous reset.
    #3; rst = 1'b1; #1;
    check("arst_zq",   32'(Z_q),     32'd0);
    check("arst_selq", 32'(sel_q),   32'd0);
    check("arst_chg",  32'(sel_chg), 32'd0);
    check("arst_cnt",  32'(chg_cnt), 32'd0);
    S = 2'b00; #1;
    check("arst_z0", 32'(Z), 32'd0);
    S = 2'b01; #1;
    check("arst_z1", 32'(Z), 32'd1);
    @(posedge clk); #1;
    check("arst_edge_cnt", 32'(chg_cnt), 32'd0);

    @(negedge clk);
    rst = 1'b0; S = 2'b01; en = 1'b1;
    @(posedge clk); #1;
    check("post_rst_chg", 32'(sel_chg), 32'd1);
    check("post_rst_cnt", 32'(chg_cnt), 32'd1);
    check("post_rst_zq",  32'(Z_q),     32'd1);

    // Toggle S every cycle: counter climbs from 1 and saturates at 255.
    for (int k = 1; k <= 300; k++) begin
      S = S ^ 2'b01;
      @(posedge clk); #1;
      if (k == 253) check("sat_253", 32'(chg_cnt), 32'd254);
      if (k == 254) check("sat_254", 32'(chg_cnt), 32'd255);
    end
    check("sat_final_cnt", 32'(chg_cnt), 32'd255);
    check("sat_final_chg", 32'(sel_chg), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ch2_4_mux.md
CH2_4_MUX -- requirements
Module: ch2_4_mux

Interface
REQ-001 Parameter DATA_W, default 1, bit width of each of the four data lanes.
REQ-002 Parameter CNT_W, default 8, width of the select-change counter.
REQ-003 clk  input  1  single clock; all registers update on the rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high; the block SHALL have no other reset.
REQ-005 I  input  4*DATA_W  data lanes; lane k occupies bits [k*DATA_W +: DATA_W], k=0..3.
REQ-006 S  input  2  lane select.
REQ-007 en  input  1  register-update enable for the registered outputs.
REQ-008 Z  output  DATA_W  combinational mux output.
REQ-009 Z_q  output  DATA_W  registered mux output.
REQ-010 sel_q  output  2  registered copy of S.
REQ-011 sel_chg  output  1  one-cycle pulse on a change of the registered select.
REQ-012 chg_cnt  output  CNT_W  saturating count of select changes.

Function
REQ-013 Z SHALL equal lane S of I combinationally: S=00->lane0, 01->lane1, 10->lane2, 11->lane3, with no clock or enable dependence.
REQ-014 Z SHALL follow any change on I or S within the same delta, with no latches inferred; X/Z on S SHALL give X on Z in simulation.
REQ-015 On a rising clk edge with en=1, Z_q SHALL load the current Z value and sel_q SHALL load S.
REQ-016 On a rising clk edge with en=0, Z_q and sel_q SHALL hold their values.
REQ-017 Z_q SHALL therefore lag Z by exactly one enabled clock edge, giving 1-cycle latency.
REQ-018 sel_chg SHALL be 1 for exactly the one cycle after an enabled edge where the loaded S differs from the previous sel_q, and 0 otherwise.
REQ-019 sel_chg SHALL be 0 after any edge with en=0.
REQ-020 chg_cnt SHALL increment by 1 on each edge where sel_chg is set.
REQ-021 chg_cnt SHALL saturate at 2^CNT_W-1 and never wrap to 0.
REQ-022 The first enabled edge after reset SHALL compare S against the reset value 00 of sel_q.
REQ-023 If S changes between edges and then returns to its original value before the next enabled edge, sel_chg SHALL NOT fire; only edge-sampled values count.
REQ-024 Simultaneous I and S changes before an edge SHALL be captured together into Z_q.

Reset
REQ-025 While rst=1, Z_q, sel_q, sel_chg and chg_cnt SHALL be 0, asynchronously and independent of clk.
REQ-026 Z SHALL remain purely combinational and functional during reset.
REQ-027 Reset asserted mid-operation SHALL clear all registers immediately, including a saturated chg_cnt.
REQ-028 After rst falls, the first rising edge SHALL operate normally per REQ-015 to REQ-022.

Verification
REQ-029 Bench SHALL drive I lane0 with period 2 (0/1), lane1 with period 6 (1/0), lane2 with period 10 (0/1) and lane3 with period 18 (1/0), DATA_W=1, and step S 00->01->10->11 every 25 time units; Z SHALL track lane0, lane1, lane2 and lane3 in turn.
REQ-030 With I=4'b1010, sweeping S=00,01,10,11 -> Z=0,1,0,1; one enabled clock after each step, Z_q equals the same value.
REQ-031 With en=0, changing S from 00 to 11 across 3 clocks -> Z_q, sel_q and chg_cnt unchanged, sel_chg=0.
REQ-032 With en=1, S toggling 00/01 every cycle for 300 cycles and CNT_W=8 -> chg_cnt reaches 255 and holds.
REQ-033 Assert rst between clock edges with chg_cnt=5 and Z_q=1 -> all registered outputs read 0 before the next edge, while Z still follows S/I.
REQ-034 With S held at 10 after reset -> first enabled edge gives sel_chg=1 and chg_cnt=1; second enabled edge gives sel_chg=0 and chg_cnt=1.
